snn_timestep_scheduler: RTL and testbench

Sequences one SNN timestep per divided-clock tick: capture input spikes, advance delay lines, run each layer in order, then publish outputs.
- Sits between the SPI configuration/memory controller and the neuron/delay datapath.
- Derives the timestep rate from div_value; runs only while input_ready is high.
- Defers configuration commits to timestep boundaries, so a timestep never sees half-written parameters.

---
 rtl/snn_sched_pkg.sv | 21 ++
 rtl/snn_tick_prescaler.sv | 32 +++
 rtl/snn_timestep_scheduler.sv | 174 +++++++++++++++++
 tb/tb_snn_timestep_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_sched_pkg.sv
// Shared definitions for the SNN timestep scheduler.
//   sched_state_t  : per-timestep sequencing states
//   NUM_LAYERS_DEF : default number of layers sequenced per timestep
//   MIN_DIV        : smallest div_value that never drops a tick when every
//                    layer answers in its first WAIT_DONE cycle
package snn_sched_pkg;

  localparam int unsigned NUM_LAYERS_DEF = 2;
  localparam int unsigned MIN_DIV        = 3 + 2 * NUM_LAYERS_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_LATCH,
    ST_SHIFT,
    ST_LAYER,
    ST_WAIT_DONE,
    ST_PUBLISH
  } sched_state_t;

endpackage

// File: rtl/snn_tick_prescaler.sv
// Timestep prescaler: emits a one-cycle tick every div_value+1 cycles while
// enable is high; the counter is held at zero whenever enable is low.
//   system_clock : block clock
//   reset        : asynchronous, active-high
//   enable       : count only while high (input_ready)
//   div_value    : period minus one, sampled live
//   tick         : high for the cycle in which count equals div_value
module snn_tick_prescaler #(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 system_clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;

  assign tick = enable && (count == div_value);

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/snn_timestep_scheduler.sv
// SNN timestep scheduler: on each prescaler tick runs one timestep
// (latch input spikes, shift delay lines, start each layer in turn and wait
// for it, publish outputs). Shadow configuration commits are deferred to
// IDLE / WAIT_TICK cycles so a timestep never sees half-written parameters.
//   system_clock, reset : clock, asynchronous active-high reset
//   input_ready         : level, run timesteps while high
//   div_value           : timestep period = div_value+1 cycles
//   cfg_update_req      : pulse, shadow configuration changed
//   layer_done          : per-layer completion, sampled only in WAIT_DONE
//   cfg_commit          : pulse, copy shadow config to active registers
//   spike_latch         : pulse, capture input spike registers
//   delay_shift         : pulse, advance all delay lines
//   layer_start         : one-hot pulse, start layer idx
//   data_valid_out      : pulse, output spikes valid
//   timestep_count      : completed timesteps in current run (wraps)
//   busy                : high in any state except IDLE
//   overrun             : sticky, a tick arrived outside WAIT_TICK
module snn_timestep_scheduler
  import snn_sched_pkg::*;
#(
  parameter int unsigned DIV_WIDTH  = 8,
  parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int unsigned TS_WIDTH   = 16
) (
  input  logic                  system_clock,
  input  logic                  reset,
  input  logic                  input_ready,
  input  logic [DIV_WIDTH-1:0]  div_value,
  input  logic                  cfg_update_req,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic                  cfg_commit,
  output logic                  spike_latch,
  output logic                  delay_shift,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic                  data_valid_out,
  output logic [TS_WIDTH-1:0]   timestep_count,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned          IDX_WIDTH = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_LAYERS - 1);

  sched_state_t          state;
  logic [IDX_WIDTH-1:0]  idx;
  logic                  tick;
  logic                  cfg_pending;
  logic                  pend_after;
  logic [NUM_LAYERS-1:0] next_layer_onehot;

  snn_tick_prescaler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_prescaler (
    .system_clock (system_clock),
    .reset        (reset),
    .enable       (input_ready),
    .div_value    (div_value),
    .tick         (tick)
  );

  // Pending state after this cycle: the commit that is firing now retires
  // the old request, while a request arriving now re-arms it.
  assign pend_after = (cfg_pending && !cfg_commit) || cfg_update_req;

  always_comb begin
    next_layer_onehot = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (i == 32'(idx) + 32'd1) begin
        next_layer_onehot[i] = 1'b1;
      end
    end
  end

  // cfg_commit is registered, so it is loaded with pend_after only on
  // transitions whose destination is IDLE or WAIT_TICK; this makes the
  // commit coincide with a quiet cycle in which cfg_pending is set.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      cfg_pending    <= 1'b0;
      cfg_commit     <= 1'b0;
      spike_latch    <= 1'b0;
      delay_shift    <= 1'b0;
      layer_start    <= '0;
      data_valid_out <= 1'b0;
      timestep_count <= '0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      cfg_commit     <= 1'b0;
      spike_latch    <= 1'b0;
      delay_shift    <= 1'b0;
      layer_start    <= '0;
      data_valid_out <= 1'b0;
      cfg_pending    <= pend_after;

      // Ticks outside WAIT_TICK are dropped; leaving IDLE below overrides.
      if (tick && (state != ST_WAIT_TICK)) begin
        overrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          cfg_commit <= pend_after;
          if (input_ready) begin
            state          <= ST_WAIT_TICK;
            busy           <= 1'b1;
            timestep_count <= '0;
            overrun        <= 1'b0;
          end
        end

        ST_WAIT_TICK: begin
          if (tick) begin
            state       <= ST_LATCH;
            spike_latch <= 1'b1;
          end else begin
            cfg_commit <= pend_after;
            if (!input_ready) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        ST_LATCH: begin
          state       <= ST_SHIFT;
          delay_shift <= 1'b1;
        end

        ST_SHIFT: begin
          state       <= ST_LAYER;
          idx         <= '0;
          layer_start <= NUM_LAYERS'(1);
        end

        ST_LAYER: begin
          state <= ST_WAIT_DONE;
        end

        ST_WAIT_DONE: begin
          if (layer_done[idx]) begin
            if (idx == LAST_IDX) begin
              state          <= ST_PUBLISH;
              data_valid_out <= 1'b1;
              timestep_count <= timestep_count + 1'b1;
            end else begin
              state       <= ST_LAYER;
              idx         <= idx + 1'b1;
              layer_start <= next_layer_onehot;
            end
          end
        end

        ST_PUBLISH: begin
          cfg_commit <= pend_after;
          if (input_ready) begin
            state <= ST_WAIT_TICK;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Self-checking bench for snn_timestep_scheduler. A timeline model predicts
// every output cycle by cycle: an accepted tick schedules the whole
// timestep's pulses into per-cycle expectation arrays, and the bench drives
// layer_done from the same schedule (plus noise the DUT must ignore).
module tb_snn_timestep_scheduler;
  import snn_sched_pkg::*;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned NL    = 2;
  localparam int unsigned TSW   = 4;
  localparam int          MAXC  = 16384;

  logic             system_clock = 1'b0;
  logic             reset;
  logic             input_ready;
  logic [DIV_W-1:0] div_value;
  logic             cfg_update_req;
  logic [NL-1:0]    layer_done;
  logic             cfg_commit;
  logic             spike_latch;
  logic             delay_shift;
  logic [NL-1:0]    layer_start;
  logic             data_valid_out;
  logic [TSW-1:0]   timestep_count;
  logic             busy;
  logic             overrun;

  always #5 system_clock = ~system_clock;

  snn_timestep_scheduler #(
    .DIV_WIDTH  (DIV_W),
    .NUM_LAYERS (NL),
    .TS_WIDTH   (TSW)
  ) dut (
    .system_clock   (system_clock),
    .reset          (reset),
    .input_ready    (input_ready),
    .div_value      (div_value),
    .cfg_update_req (cfg_update_req),
    .layer_done     (layer_done),
    .cfg_commit     (cfg_commit),
    .spike_latch    (spike_latch),
    .delay_shift    (delay_shift),
    .layer_start    (layer_start),
    .data_valid_out (data_valid_out),
    .timestep_count (timestep_count),
    .busy           (busy),
    .overrun        (overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model timeline
  int       cyc = 0;
  bit       e_latch [MAXC];
  bit       e_shift [MAXC];
  bit       e_dv    [MAXC];
  bit [1:0] e_ls    [MAXC];
  bit [1:0] ld_drv  [MAXC];
  bit       covered [MAXC];
  bit       m_active;
  int       ts_pub;
  int       pc;
  bit       pending;
  int       cnt;
  bit       ovr;

  // Stimulus controls
  bit g_rdy          = 1'b0;
  int g_div          = 0;
  int g_req_pct      = 0;
  int g_dmax         = 0;
  int g_d0_force     = -1;
  int g_d1_force     = -1;
  bit g_drop_at_ls0  = 1'b0;
  bit g_req_directed = 1'b0;
  bit pair_toggle    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    m_active = 1'b0;
    ts_pub   = -1;
    pc       = 0;
    pending  = 1'b0;
    cnt      = 0;
    ovr      = 1'b0;
    for (int i = cyc; i < MAXC; i++) begin
      e_latch[i] = 1'b0;
      e_shift[i] = 1'b0;
      e_dv[i]    = 1'b0;
      e_ls[i]    = 2'b00;
      ld_drv[i]  = 2'b00;
      covered[i] = 1'b0;
    end
  endtask

  // Plan a timestep whose tick is accepted in cycle t.
  task automatic schedule(input int t);
    int d0, d1, p;
    d0 = (g_d0_force >= 0) ? g_d0_force : int'($urandom_range(0, g_dmax));
    d1 = (g_d1_force >= 0) ? g_d1_force : int'($urandom_range(0, g_dmax));
    p  = t + 7 + d0 + d1;
    for (int k = t + 1; k <= p; k++) begin
      covered[k] = 1'b1;
      ld_drv[k]  = 2'($urandom);
    end
    for (int k = t + 4; k < t + 4 + d0; k++) ld_drv[k][0] = 1'b0;
    ld_drv[t + 4 + d0][0] = 1'b1;
    for (int k = t + 6 + d0; k < t + 6 + d0 + d1; k++) ld_drv[k][1] = 1'b0;
    ld_drv[t + 6 + d0 + d1][1] = 1'b1;
    e_latch[t + 1]       = 1'b1;
    e_shift[t + 2]       = 1'b1;
    e_ls[t + 3][0]       = 1'b1;
    e_ls[t + 5 + d0][1]  = 1'b1;
    e_dv[p]              = 1'b1;
    ts_pub               = p;
  endtask

  // Called just after the edge that starts cycle cyc: check, drive, advance.
  task automatic step_cycle();
    bit       in_ts, commit_c, tick, req;
    bit [1:0] ldv;
    in_ts    = m_active && (cyc <= ts_pub);
    commit_c = pending && !in_ts;

    chk("busy",           busy,           32'(m_active));
    chk("timestep_count", timestep_count, 32'(cnt % (1 << TSW)));
    chk("overrun",        overrun,        32'(ovr));
    chk("cfg_commit",     cfg_commit,     32'(commit_c));
    chk("spike_latch",    spike_latch,    32'(e_latch[cyc]));
    chk("delay_shift",    delay_shift,    32'(e_shift[cyc]));
    chk("layer_start",    layer_start,    32'(e_ls[cyc]));
    chk("data_valid_out", data_valid_out, 32'(e_dv[cyc]));

    if (g_drop_at_ls0 && e_ls[cyc][0]) begin
      g_rdy         = 1'b0;
      g_drop_at_ls0 = 1'b0;
    end
    if (g_req_directed) begin
      req = (cyc > 0) && e_ls[cyc - 1][0];
      if (commit_c) begin
        req         = req || !pair_toggle;
        pair_toggle = !pair_toggle;
      end
    end else begin
      req = ($urandom_range(0, 99) < g_req_pct);
    end
    ldv = covered[cyc] ? ld_drv[cyc] : 2'($urandom);

    input_ready    = g_rdy;
    div_value      = DIV_W'(g_div);
    cfg_update_req = req;
    layer_done     = ldv;

    tick    = g_rdy && (pc == g_div);
    pc      = (!g_rdy || tick) ? 0 : (pc + 1) % (1 << DIV_W);
    pending = (pending && !commit_c) || req;
    if (!m_active) begin
      if (g_rdy) begin
        m_active = 1'b1;
        cnt      = 0;
        ovr      = 1'b0;
      end
    end else if (!in_ts) begin
      if (tick) schedule(cyc);
      else if (!g_rdy) m_active = 1'b0;
    end else begin
      if (tick) ovr = 1'b1;
      if (cyc + 1 == ts_pub) cnt++;
      if (cyc == ts_pub) m_active = g_rdy;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge system_clock);
      #1;
      step_cycle();
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"},    busy,           32'd0);
    chk({tag, "_commit"},  cfg_commit,     32'd0);
    chk({tag, "_latch"},   spike_latch,    32'd0);
    chk({tag, "_shift"},   delay_shift,    32'd0);
    chk({tag, "_lstart"},  layer_start,    32'd0);
    chk({tag, "_dvalid"},  data_valid_out, 32'd0);
    chk({tag, "_count"},   timestep_count, 32'd0);
    chk({tag, "_overrun"}, overrun,        32'd0);
  endtask

  // Asserts reset mid-cycle, holds it across one edge, releases it and
  // resumes the model from the reset state in the current cycle.
  task automatic apply_reset();
    #2;
    reset          = 1'b1;
    g_rdy          = 1'b0;
    input_ready    = 1'b0;
    cfg_update_req = 1'b0;
    layer_done     = '0;
    #1;
    check_quiet("rst_async");
    @(posedge system_clock);
    #1;
    check_quiet("rst_held");
    reset = 1'b0;
    #1;
    cyc++;
    model_clear();
    step_cycle();
  endtask

  initial begin
    reset          = 1'b1;
    input_ready    = 1'b0;
    div_value      = '0;
    cfg_update_req = 1'b0;
    layer_done     = '0;
    model_clear();
    apply_reset();
    run(5);

    // Reset while parked in WAIT_DONE for layer 0.
    g_div = MIN_DIV; g_d0_force = 30; g_rdy = 1'b1;
    run(15);
    apply_reset();
    g_d0_force = -1;
    run(3);

    // Steady run at the minimum overrun-free period: five timesteps.
    g_dmax = 0; g_div = MIN_DIV; g_rdy = 1'b1;
    run(48);
    chk("five_ts_count",   timestep_count, 32'd5);
    chk("five_ts_overrun", overrun,        32'd0);

    // Period too short: ticks are dropped and overrun sticks until restart.
    g_rdy = 1'b0; run(20);
    g_div = MIN_DIV - 4; g_rdy = 1'b1;
    run(40);
    chk("short_div_overrun", overrun, 32'd1);
    g_rdy = 1'b0; run(12);
    g_rdy = 1'b1; run(2);
    chk("restart_clears_overrun", overrun, 32'd0);

    // Config requests during WAIT_DONE, plus a re-request in the commit cycle.
    g_rdy = 1'b0; run(15);
    g_div = 9; g_req_directed = 1'b1; pair_toggle = 1'b0; g_rdy = 1'b1;
    run(60);
    g_req_directed = 1'b0;

    // input_ready dropped while layer 0 is starting.
    g_rdy = 1'b0; run(15);
    g_div = MIN_DIV; g_drop_at_ls0 = 1'b1; g_rdy = 1'b1;
    run(30);
    g_drop_at_ls0 = 1'b0;
    chk("drop_idle_busy", busy, 32'd0);
    g_rdy = 1'b1; run(20);

    // Slow last layer with layer 0 noise while it waits.
    g_rdy = 1'b0; run(15);
    g_div = 40; g_d1_force = 20; g_rdy = 1'b1;
    run(90);
    g_d1_force = -1;

    // Randomised segments.
    g_dmax = 2; g_req_pct = 10;
    for (int s = 0; s < 40; s++) begin
      g_rdy = 1'b0;
      run(int'($urandom_range(1, 12)));
      g_div = int'($urandom_range(0, 15));
      g_rdy = 1'b1;
      run(int'($urandom_range(20, 150)));
    end
    g_rdy = 1'b0; g_req_pct = 0;
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
